// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Accepts "count N steps up/down" commands over valid/ready, buffers them in
//   a DEPTH-entry FIFO and plays them out one at a time on en/up_dn, which
//   drive a downstream counter directly. Each command ends with a one-cycle
//   done pulse.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   cmd_valid/ready - command handshake; cmd_up = direction, cmd_len = steps
//   hold            - pause RUN without losing progress
//   abort           - flush FIFO and return to IDLE (no done)
//   en, up_dn       - counter enable / direction
//   busy, done      - state != IDLE / completion pulse
//   fifo_count      - commands currently buffered
module counter_sequencer #(
    parameter int LEN_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_up,
    input  logic [LEN_W-1:0]         cmd_len,
    input  logic                     hold,
    input  logic                     abort,
    output logic                     en,
    output logic                     up_dn,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic             up;
        logic [LEN_W-1:0] len;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    cmd_t              mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, push, pop;
    cmd_t              head;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  remaining;
    logic              dir_q;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full && !rst && !abort;
    assign push      = cmd_valid && cmd_ready;
    // Only IDLE pops; the FIFO has no bypass, so a fresh write waits a cycle.
    assign pop       = (state_q == IDLE) && !empty && !abort;
    assign head      = mem[rd_ptr];

    assign en         = (state_q == RUN) && !hold && !abort;
    assign up_dn      = dir_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign fifo_count = count;

    // Storage is not reset; push is already blocked during rst/abort.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{up: cmd_up, len: cmd_len};
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pop) state_d = (head.len != '0) ? RUN : DONE;
            RUN:  if (en && remaining == LEN_W'(1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            remaining <= '0;
            dir_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (abort) begin
                remaining <= '0;
            end else if (pop) begin
                remaining <= head.len;
                dir_q     <= head.up;
            end else if (en) begin
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Directed bench for counter_sequencer. A behavioural counter follows en/up_dn
//   so step totals and final counts can be checked against hand-computed values.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_ready, cmd_up, hold, abort;
    logic [7:0] cmd_len;
    logic       en, up_dn, busy, done;
    logic [2:0] fifo_count;

    counter_sequencer #(.LEN_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_up(cmd_up), .cmd_len(cmd_len), .hold(hold), .abort(abort),
        .en(en), .up_dn(up_dn), .busy(busy), .done(done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc_n = 0;
    int cnt, en_tot, done_tot, run_cyc, first_en, done_at;
    int cur, nruns, gap, bad_gap;
    int runl [8];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic clr();
        cnt = 0; en_tot = 0; done_tot = 0; run_cyc = 0;
        first_en = -1; done_at = -1;
        cur = 0; nruns = 0; gap = 0; bad_gap = 0;
    endtask

    // One clock: inputs already applied after a negedge; sample mid-cycle,
    // then advance to the next negedge.
    task automatic cyc();
        #1;
        if (en && !rst) begin
            cnt += up_dn ? 1 : -1;
            en_tot++;
            if (first_en < 0) first_en = cyc_n;
            if (cur == 0 && nruns > 0 && gap != 2) bad_gap++;
            cur++;
            gap = 0;
        end else begin
            if (cur > 0) begin
                if (nruns < 8) runl[nruns] = cur;
                nruns++;
                cur = 0;
            end
            gap++;
        end
        if (done) begin done_tot++; done_at = cyc_n; end
        if (busy && !done) run_cyc++;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic push(input logic up, input int len);
        cmd_valid = 1'b1; cmd_up = up; cmd_len = 8'(len);
        cyc();
        cmd_valid = 1'b0;
    endtask

    int p, hc, rdy, guard;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_up = 1'b0; cmd_len = '0;
        hold = 1'b0; abort = 1'b0;
        clr();
        cyc(); cyc();

        // Reset state
        chk("rst_en", en, 0);
        chk("rst_up_dn", up_dn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1 chk("cmd_ready_after_rst", cmd_ready, 1);

        // Up by 3: en on cycles p+2..p+4, done on p+5
        clr();
        p = cyc_n;
        push(1'b1, 3);
        repeat (8) cyc();
        chk("t1_en_cycles", en_tot, 3);
        chk("t1_done_pulses", done_tot, 1);
        chk("t1_count", cnt, 3);
        chk("t1_first_en_latency", first_en - p, 2);
        chk("t1_done_after_first_en", done_at - first_en, 3);
        chk("t1_up_dn", up_dn, 1);
        chk("t1_idle", busy, 0);

        // Zero-length down command
        clr();
        p = cyc_n;
        push(1'b0, 0);
        repeat (5) cyc();
        chk("t2_en_cycles", en_tot, 0);
        chk("t2_done_pulses", done_tot, 1);
        chk("t2_done_latency", done_at - p, 2);
        chk("t2_up_dn", up_dn, 0);

        // Len 5 with 2 hold cycles after the 2nd step
        clr();
        hc = 0;
        push(1'b1, 5);
        guard = 0;
        while (done_tot == 0 && guard < 40) begin
            hold = (en_tot == 2 && hc < 2);
            if (hold) hc++;
            cyc();
            guard++;
        end
        hold = 1'b0;
        chk("t3_timeout", guard < 40, 1);
        chk("t3_en_cycles", en_tot, 5);
        chk("t3_run_cycles", run_cyc, 7);
        chk("t3_count", cnt, 5);
        cyc(); cyc();

        // Five pushes under hold: lens 1..5, alternating up/down
        clr();
        hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1; cmd_up = (i % 2 == 0); cmd_len = 8'(i + 1);
            #1 rdy = cmd_ready;
            if (i == 5) chk("t4_ready_6th", rdy, 0);
            else        chk("t4_ready_push", rdy, 1);
            cyc();
        end
        cmd_valid = 1'b0;
        chk("t4_fifo_count_full", fifo_count, 4);
        chk("t4_busy_held", busy, 1);
        chk("t4_no_en_held", en_tot, 0);
        hold = 1'b0;
        clr();
        guard = 0;
        while (done_tot < 5 && guard < 100) begin cyc(); guard++; end
        cyc();
        chk("t4_timeout", guard < 100, 1);
        chk("t4_done_pulses", done_tot, 5);
        chk("t4_en_cycles", en_tot, 15);
        chk("t4_nruns", nruns, 5);
        for (int k = 0; k < 5; k++) chk($sformatf("t4_run_len%0d", k), runl[k], k + 1);
        chk("t4_bad_gaps", bad_gap, 0);
        chk("t4_count", cnt, 3);
        chk("t4_fifo_empty", fifo_count, 0);

        // Abort during the 4th step of the first of three len-10 commands
        clr();
        push(1'b1, 10); push(1'b1, 10); push(1'b1, 10);
        guard = 0;
        while (en_tot < 3 && guard < 20) begin cyc(); guard++; end
        chk("t5_timeout", guard < 20, 1);
        chk("t5_fifo_before", fifo_count, 2);
        abort = 1'b1;
        #1 chk("t5_en_in_abort", en, 0);
        cyc();
        abort = 1'b0;
        chk("t5_fifo_after", fifo_count, 0);
        chk("t5_busy_after", busy, 0);
        repeat (6) cyc();
        chk("t5_en_cycles", en_tot, 3);
        chk("t5_done_pulses", done_tot, 0);

        // Reset during RUN of a len-8 down command after 3 steps
        clr();
        push(1'b0, 8);
        push(1'b1, 2);
        guard = 0;
        while (en_tot < 3 && guard < 20) begin cyc(); guard++; end
        chk("t6_timeout", guard < 20, 1);
        rst = 1'b1;
        cyc();
        chk("t6_en", en, 0);
        chk("t6_up_dn", up_dn, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_fifo_count", fifo_count, 0);
        chk("t6_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        repeat (10) cyc();
        chk("t6_en_cycles", en_tot, 3);
        chk("t6_count", cnt, -3);
        chk("t6_done_pulses", done_tot, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
